// File: rtl/popcount_stream.sv
// popcount_stream: accepts one word over valid/ready, counts its ones (or zeros)
// CHUNKWIDTH bits per clock, and returns the count over a second valid/ready.
module popcount_stream #(
  parameter int DATAWIDTH  = 16,
  parameter int CHUNKWIDTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_Valid,
  output logic                       o_Ready,
  input  logic [DATAWIDTH-1:0]       i_DataIn,
  input  logic                       i_CountZeros,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [$clog2(DATAWIDTH):0] o_Count,
  output logic                       o_Busy
);

  localparam int NCHUNK = DATAWIDTH / CHUNKWIDTH;
  localparam int CNT_W  = $clog2(DATAWIDTH) + 1;
  localparam int PC_W   = $clog2(CHUNKWIDTH) + 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (DATAWIDTH % CHUNKWIDTH != 0) begin : g_bad_chunk
      $error("popcount_stream: DATAWIDTH must be a multiple of CHUNKWIDTH");
    end
  endgenerate

  function automatic logic [PC_W-1:0] popcnt(input logic [CHUNKWIDTH-1:0] c);
    logic [PC_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNKWIDTH; i++) begin
      s = s + PC_W'(c[i]);
    end
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DATAWIDTH-1:0] word_p0;
  logic [DATAWIDTH-1:0] word_shift;
  logic [CNT_W-1:0]     acc_p0;
  logic [CNT_W-1:0]     sum;
  logic [CNT_W-1:0]     count_p1;
  logic [IDX_W-1:0]     idx_p0;
  logic                 last;

  // The latched word is shifted down one chunk per COUNT cycle, so the
  // chunk being counted is always the low CHUNKWIDTH bits.
  generate
    if (NCHUNK > 1) begin : g_shift
      assign word_shift = {{CHUNKWIDTH{1'b0}}, word_p0[DATAWIDTH-1:CHUNKWIDTH]};
    end else begin : g_noshift
      assign word_shift = '0;
    end
  endgenerate

  assign last = (idx_p0 == LAST_IDX);
  assign sum  = acc_p0 + CNT_W'(popcnt(word_p0[CHUNKWIDTH-1:0]));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Valid) state_nxt = COUNT;
      COUNT:   if (last)    state_nxt = DONE;
      DONE:    if (i_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: word capture and chunk accumulation; stage p1: published result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      word_p0  <= '0;
      acc_p0   <= '0;
      idx_p0   <= '0;
      count_p1 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_Valid) begin
            word_p0 <= i_CountZeros ? ~i_DataIn : i_DataIn;
            acc_p0  <= '0;
            idx_p0  <= '0;
          end
        end
        COUNT: begin
          word_p0 <= word_shift;
          acc_p0  <= sum;
          idx_p0  <= idx_p0 + IDX_W'(1);
          if (last) count_p1 <= sum;
        end
        default: ;
      endcase
    end
  end

  assign o_Ready = (state == IDLE);
  assign o_Busy  = (state != IDLE);
  assign o_Valid = (state == DONE);
  assign o_Count = count_p1;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: a 4-bit-chunk and a full-width-chunk instance,
// each compared every cycle against a timeline model of accept/count/deliver.
module tb_popcount_stream;

  localparam int DW = 16;
  localparam int CW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          v   [2];
  logic [DW-1:0] d   [2];
  logic          cz  [2];
  logic          rdy [2];
  wire           ordy  [2];
  wire           ovld  [2];
  wire           obusy [2];
  wire [CW-1:0]  ocnt  [2];

  int nch [2] = '{4, 1};

  bit m_busy  [2];
  bit m_valid [2];
  int m_since [2];
  int m_res   [2];
  int m_count [2];

  longint accq0[$];
  longint accq1[$];
  int     resq0[$];
  int     resq1[$];

  int n_chk  = 0;
  int n_pass = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  popcount_stream #(.DATAWIDTH(DW), .CHUNKWIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_Valid(v[0]), .o_Ready(ordy[0]),
    .i_DataIn(d[0]), .i_CountZeros(cz[0]), .o_Valid(ovld[0]),
    .i_Ready(rdy[0]), .o_Count(ocnt[0]), .o_Busy(obusy[0])
  );

  popcount_stream #(.DATAWIDTH(DW), .CHUNKWIDTH(16)) dut_deg (
    .i_clk(clk), .i_rst(rst), .i_Valid(v[1]), .o_Ready(ordy[1]),
    .i_DataIn(d[1]), .i_CountZeros(cz[1]), .o_Valid(ovld[1]),
    .i_Ready(rdy[1]), .o_Count(ocnt[1]), .o_Busy(obusy[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
  endtask

  // Model: a word is accepted when idle, its result appears NCHUNK edges
  // later, and it is released on the first edge the consumer is ready.
  task automatic model_step(input int i);
    if (rst) begin
      m_busy[i]  = 1'b0;
      m_valid[i] = 1'b0;
      m_since[i] = 0;
      m_count[i] = 0;
    end else if (!m_busy[i]) begin
      if (v[i]) begin
        m_busy[i]  = 1'b1;
        m_since[i] = 0;
        m_res[i]   = $countones(cz[i] ? ~d[i] : d[i]);
        if (i == 0) accq0.push_back($time); else accq1.push_back($time);
      end
    end else if (!m_valid[i]) begin
      m_since[i]++;
      if (m_since[i] == nch[i]) begin
        m_valid[i] = 1'b1;
        m_count[i] = m_res[i];
      end
    end else if (rdy[i]) begin
      m_valid[i] = 1'b0;
      m_busy[i]  = 1'b0;
      if (i == 0) resq0.push_back(m_count[i]); else resq1.push_back(m_count[i]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step(0);
      model_step(1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("d%0d_ready", i), 32'(ordy[i]),  32'(!m_busy[i]));
          chk($sformatf("d%0d_busy", i),  32'(obusy[i]), 32'(m_busy[i]));
          chk($sformatf("d%0d_valid", i), 32'(ovld[i]),  32'(m_valid[i]));
          chk($sformatf("d%0d_count", i), 32'(ocnt[i]),  32'(m_count[i]));
        end
      end
    end
  end

  function automatic int acc_n(input int i);
    if (i == 0) return accq0.size();
    return accq1.size();
  endfunction

  function automatic longint acc_at(input int i, input int k);
    if (i == 0) return accq0[k];
    return accq1[k];
  endfunction

  function automatic int res_n(input int i);
    if (i == 0) return resq0.size();
    return resq1.size();
  endfunction

  function automatic int res_at(input int i, input int k);
    if (i == 0) return resq0[k];
    return resq1[k];
  endfunction

  task automatic do_word(input int i, input logic [DW-1:0] w, input logic z,
                         input int hold, input int exp_lat, input int exp_cnt,
                         input string name);
    int n;
    @(negedge clk);
    v[i] = 1'b1; d[i] = w; cz[i] = z; rdy[i] = 1'b0;
    n = 0;
    while (!ordy[i] && n < 50) begin @(negedge clk); n++; end
    chk({name, "_accept"}, 32'(ordy[i]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v[i] = 1'b0; d[i] = DW'($urandom); cz[i] = 1'($urandom_range(0, 1));
    n = 0;
    while (!ovld[i] && n < 50) begin
      v[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(exp_lat));
    chk({name, "_cnt"}, 32'(ocnt[i]), 32'(exp_cnt));
    repeat (hold) begin
      v[i] = 1'($urandom_range(0, 1)); d[i] = DW'($urandom);
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(ovld[i]), 32'd1);
      chk({name, "_hold_cnt"},   32'(ocnt[i]), 32'(exp_cnt));
      chk({name, "_hold_ready"}, 32'(ordy[i]), 32'd0);
    end
    v[i] = 1'b0; rdy[i] = 1'b1;
    @(negedge clk);
    rdy[i] = 1'b0;
    chk({name, "_released"}, 32'(ordy[i]), 32'd1);
    chk({name, "_kept_cnt"}, 32'(ocnt[i]), 32'(exp_cnt));
  endtask

  task automatic b2b(input int i, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                     input int period, input int e0, input int e1, input string name);
    int n;
    if (i == 0) begin accq0.delete(); resq0.delete(); end
    else begin accq1.delete(); resq1.delete(); end
    @(negedge clk);
    v[i] = 1'b1; d[i] = w0; cz[i] = 1'b0; rdy[i] = 1'b1;
    n = 0;
    while (acc_n(i) < 1 && n < 50) begin @(negedge clk); n++; end
    d[i] = w1;
    n = 0;
    while (res_n(i) < 2 && n < 50) begin @(negedge clk); n++; end
    v[i] = 1'b0; rdy[i] = 1'b0;
    chk({name, "_nres"}, 32'(res_n(i)), 32'd2);
    if (res_n(i) >= 2 && acc_n(i) >= 2) begin
      chk({name, "_period"}, 32'((acc_at(i, 1) - acc_at(i, 0)) / 10), 32'(period));
      chk({name, "_res0"}, 32'(res_at(i, 0)), 32'(e0));
      chk({name, "_res1"}, 32'(res_at(i, 1)), 32'(e1));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; d[i] = '0; cz[i] = 1'b0; rdy[i] = 1'b0;
    end
    run = 1'b1;
    #12;
    chk("rst_ready", 32'(ordy[0]),  32'd1);
    chk("rst_valid", 32'(ovld[0]),  32'd0);
    chk("rst_busy",  32'(obusy[0]), 32'd0);
    chk("rst_count", 32'(ocnt[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_word(0, 16'b1011111100011111, 1'b0, 0, 4, 12, "ones");
    do_word(0, 16'hFFFE, 1'b1, 0, 4, 1,  "zeros_fffe");
    do_word(0, 16'h0000, 1'b1, 2, 4, 16, "zeros_0000");
    do_word(0, 16'hFFFF, 1'b0, 0, 4, 16, "ones_ffff");
    do_word(0, 16'hA5C3, 1'b0, 5, 4, 8,  "backpressure");

    @(negedge clk);
    v[0] = 1'b1; d[0] = 16'hFFFF; cz[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ordy[0]),  32'd1);
    chk("midrst_busy",  32'(obusy[0]), 32'd0);
    chk("midrst_valid", 32'(ovld[0]),  32'd0);
    chk("midrst_count", 32'(ocnt[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_word(0, 16'h0001, 1'b0, 0, 4, 1, "after_rst");

    b2b(0, 16'hFFFF, 16'h8001, 6, 16, 2, "b2b");

    do_word(1, 16'hF0F0, 1'b0, 1, 1, 8, "deg");
    b2b(1, 16'hF0F0, 16'h0001, 3, 8, 1, "deg_b2b");

    repeat (800) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        v[i]   = ($urandom_range(0, 3) != 0);
        d[i]   = DW'($urandom);
        cz[i]  = 1'($urandom_range(0, 1));
        rdy[i] = 1'($urandom_range(0, 1));
      end
    end

    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; rdy[i] = 1'b1;
    end
    repeat (20) @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
